// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a register-file FIFO: addresses, occupancy flags, rd_valid.
// Optional sticky overflow/underflow flags enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned AF_THRESH     = 14,
    parameter int unsigned AE_THRESH     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr,
    input  logic                     rd,
    output logic [ADDRESS_WIDTH-1:0] w_addr,
    output logic [ADDRESS_WIDTH-1:0] r_addr,
    output logic                     wr_en,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int unsigned AW    = ADDRESS_WIDTH;
    localparam int unsigned LW    = ADDRESS_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          rd_valid_q, rd_valid_d;
    logic          push_ok, pop_ok;

    // Full blocks the push even when a pop frees a slot, so the same slot is never written and read on one edge.
    always_comb begin
        push_ok    = wr & ~full_q;
        pop_ok     = rd & ~empty_q;
        w_ptr_d    = w_ptr_q + AW'(push_ok);
        r_ptr_d    = r_ptr_q + AW'(pop_ok);
        level_d    = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == '0);
        af_d       = (level_d >= LW'(AF_THRESH));
        ae_d       = (level_d <= LW'(AE_THRESH));
        rd_valid_d = pop_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign w_addr       = w_ptr_q;
    assign r_addr       = r_ptr_q;
    assign wr_en        = push_ok;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags; a new drop wins over err_clr on the same edge.
    always_comb begin
        overflow_d  = (wr & ~push_ok) | (overflow_q & ~err_clr);
        underflow_d = (rd & empty_q) | (underflow_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: vector table, directed corner sequences, random traffic vs queue model.
module tb_fifo_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          reset_n, wr, rd;
    logic [AW-1:0] w_addr, r_addr;
    logic          wr_en, rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   level;
    logic          err_clr;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow, underflow;
`endif

    fifo_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .wr_en        (wr_en),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Storage model: register file with 1-cycle registered read.
    logic [7:0] mem [DEPTH];
    logic [7:0] r_data, wdata;
    always @(posedge clk) begin
        if (wr_en) mem[w_addr] <= wdata;
        r_data <= mem[r_addr];
    end

    // Behavioural reference model.
    logic [7:0]  q[$];
    int unsigned n_push, n_pop;
    bit          exp_rv;
    logic [7:0]  exp_data;
    bit          ovf_m, unf_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = q.size();
        check({tag, " level"}, 32'(level), 32'(sz));
        check({tag, " empty"}, 32'(empty), 32'(sz == 0));
        check({tag, " full"}, 32'(full), 32'(sz == DEPTH));
        check({tag, " almost_full"}, 32'(almost_full), 32'(sz >= AF));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        check({tag, " w_addr"}, 32'(w_addr), n_push % DEPTH);
        check({tag, " r_addr"}, 32'(r_addr), n_pop % DEPTH);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(exp_rv));
        if (exp_rv) check({tag, " r_data"}, 32'(r_data), 32'(exp_data));
`ifdef FIFO_ERR_FLAGS_EN
        check({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
        check({tag, " underflow"}, 32'(underflow), 32'(unf_m));
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input bit w, input bit r, input string tag);
        int sz;
        bit push_ok, pop_ok;
        wr    = w;
        rd    = r;
        wdata = 8'($urandom);
        #1;
        sz      = q.size();
        push_ok = w && (sz < DEPTH);
        pop_ok  = r && (sz > 0);
        check({tag, " wr_en"}, 32'(wr_en), 32'(push_ok));
        @(posedge clk);
        ovf_m  = (w && sz == DEPTH) || (ovf_m && !err_clr);
        unf_m  = (r && sz == 0) || (unf_m && !err_clr);
        exp_rv = pop_ok;
        if (pop_ok) begin
            exp_data = q.pop_front();
            n_pop++;
        end
        if (push_ok) begin
            q.push_back(wdata);
            n_push++;
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        wr      = 1'b1;
        rd      = 1'b1;
        @(posedge clk);
        q.delete();
        n_push = 0;
        n_pop  = 0;
        exp_rv = 1'b0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        @(negedge clk);
        check_state(tag);
        reset_n = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
    endtask

    typedef struct {
        bit wr;
        bit rd;
        int lvl;
        bit emp;
        bit ful;
        bit ae;
        bit af;
        bit rv;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int pw, pr;
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        wdata   = '0;

        tbl[0] = '{1, 1, 1, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 0, 1, 0, 1};
        tbl[2] = '{0, 1, 0, 1, 0, 1, 0, 0};
        tbl[3] = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 0, 2, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 0, 3, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 1, 3, 0, 0, 0, 0, 1};
        tbl[7] = '{0, 0, 3, 0, 0, 0, 0, 0};

        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < 8; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].wr, tbl[i].rd, t);
            check({t, " tbl_level"}, 32'(level), 32'(tbl[i].lvl));
            check({t, " tbl_empty"}, 32'(empty), 32'(tbl[i].emp));
            check({t, " tbl_full"}, 32'(full), 32'(tbl[i].ful));
            check({t, " tbl_ae"}, 32'(almost_empty), 32'(tbl[i].ae));
            check({t, " tbl_af"}, 32'(almost_full), 32'(tbl[i].af));
            check({t, " tbl_rv"}, 32'(rd_valid), 32'(tbl[i].rv));
        end

        // Fill to full, then one dropped push.
        do_reset("fill_rst");
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, "fill");
            check("fill level_seq", 32'(level), 32'(i));
            check("fill af_seq", 32'(almost_full), 32'(i >= 14));
        end
        check("fill w_addr_wrap", 32'(w_addr), 32'd0);
        check("fill full_set", 32'(full), 32'd1);
        step(1'b1, 1'b0, "push_full");
        check("push_full level_hold", 32'(level), 32'd16);

        // Drain to empty, then one dropped pop.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, "drain");
            check("drain rv_seq", 32'(rd_valid), 32'd1);
            check("drain level_seq", 32'(level), 32'(16 - i));
        end
        check("drain empty_set", 32'(empty), 32'd1);
        step(1'b0, 1'b1, "pop_empty");
        check("pop_empty no_rv", 32'(rd_valid), 32'd0);

        // Level 5 with wr&rd held 20 cycles.
        do_reset("both_rst");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "both_fill");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "both");
        check("both level_5", 32'(level), 32'd5);
        check("both w_addr", 32'(w_addr), 32'd9);
        check("both r_addr", 32'(r_addr), 32'd4);

        // Full with wr&rd: pop only.
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, "refill");
        step(1'b1, 1'b1, "full_both");
        check("full_both level_15", 32'(level), 32'd15);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "full_both_drain");

        // Reset mid-stream at level 8 with rd_valid high.
        do_reset("mid_rst0");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "mid_fill");
        step(1'b1, 1'b1, "mid_both");
        check("mid rv_before", 32'(rd_valid), 32'd1);
        do_reset("mid_rst");
        check("mid level_0", 32'(level), 32'd0);
        check("mid rv_drop", 32'(rd_valid), 32'd0);

`ifdef FIFO_ERR_FLAGS_EN
        do_reset("err_rst");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, "err_fill");
        step(1'b1, 1'b0, "err_ovf");
        check("err ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, "err_hold");
        check("err ovf_hold", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b0, "err_clr");
        check("err ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, "err_clr_set");
        check("err set_wins", 32'(overflow), 32'd1);
        err_clr = 1'b0;
        do_reset("err_rst2");
        step(1'b0, 1'b1, "err_unf");
        check("err unf_set", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b0, "err_unf_clr");
        check("err unf_clr", 32'(underflow), 32'd0);
        err_clr = 1'b0;
`endif

        // Random traffic in phases biased toward fill, drain and balance.
        do_reset("rand_rst");
        for (int i = 0; i < 3000; i++) begin
            case ((i / 300) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 25; pr = 80; end
                default: begin pw = 55; pr = 55; end
            endcase
`ifdef FIFO_ERR_FLAGS_EN
            err_clr = ($urandom_range(0, 99) < 5);
`endif
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, "rand");
            if (($urandom_range(0, 999)) == 0) do_reset("rand_mid_rst");
        end
        err_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
